// File: rtl/or4_sweep_checker.sv
// Stimulus/check engine for a 4-input OR tree: sweeps all 16 vectors and counts mismatching ones.
// Optional first-failure capture is enabled by defining OR4_CHK_LOG_EN.
module or4_sweep_checker #(
   parameter int unsigned SETTLE        = 1,
   parameter bit          CHECK_PARTIAL = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic [3:0] dut_in,
   input  logic       dut_s,
   input  logic       dut_t,
   input  logic       dut_e,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [4:0] err_count
`ifdef OR4_CHK_LOG_EN
   ,
   output logic       first_fail_vld,
   output logic [3:0] first_fail_vec
`endif
);

   typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_WAIT, S_CHECK, S_DONE} state_t;

   localparam logic [3:0] SETTLE_W = 4'(SETTLE);

   state_t     state;
   logic [3:0] vec;
   logic [3:0] cnt;
   logic       exp_s;
   logic       exp_t;
   logic       exp_e;
   logic       mismatch;

   // In CHECK, dut_in already holds vec, so expectations come straight from vec.
   always_comb begin
      exp_s    = vec[3] | vec[2];
      exp_t    = vec[1] | vec[0];
      exp_e    = exp_s | exp_t;
      mismatch = (dut_e != exp_e) || (CHECK_PARTIAL && ((dut_s != exp_s) || (dut_t != exp_t)));
   end

   // NOTE: every register here, including the result outputs, is async-reset so a mid-sweep
   // reset leaves no stale partial result; all state updates use non-blocking assignments.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         vec       <= '0;
         cnt       <= '0;
         dut_in    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= '0;
`ifdef OR4_CHK_LOG_EN
         first_fail_vld <= 1'b0;
         first_fail_vec <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  done      <= 1'b0;
                  pass      <= 1'b0;
                  err_count <= '0;
                  vec       <= '0;
                  busy      <= 1'b1;
                  state     <= S_DRIVE;
`ifdef OR4_CHK_LOG_EN
                  first_fail_vld <= 1'b0;
                  first_fail_vec <= '0;
`endif
               end
            end
            S_DRIVE: begin
               dut_in <= vec;
               cnt    <= SETTLE_W;
               state  <= (SETTLE_W == 4'd0) ? S_CHECK : S_WAIT;
            end
            S_WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) state <= S_CHECK;
            end
            S_CHECK: begin
               if (mismatch) err_count <= err_count + 5'd1;
`ifdef OR4_CHK_LOG_EN
               if (mismatch && !first_fail_vld) begin
                  first_fail_vld <= 1'b1;
                  first_fail_vec <= vec;
               end
`endif
               // Exit on vec==15 so the 4-bit counter never wraps into a 17th check.
               if (vec == 4'd15) begin
                  busy  <= 1'b0;
                  state <= S_DONE;
               end else begin
                  vec   <= vec + 4'd1;
                  state <= S_DRIVE;
               end
            end
            S_DONE: begin
               done  <= 1'b1;
               pass  <= (err_count == 5'd0);
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
